aim_servo_controller: RTL and testbench
=======================================

// Module: aim_servo_controller
// PURPOSE
//  Downstream of the red-region tracker. Once per frame it picks one target from the 16 region results.
//  It converts that target's pixel error from the screen centre into pan/tilt servo pulse widths.
//  It drives two 50 Hz hobby-servo PWM outputs. The tracking loop closes through the camera mount.
// PARAMETERS
//  CLK_PER_US   25     clk cycles per 1 us PWM tick (25 MHz system clock)
//  PERIOD_US    20000  PWM frame length in us (50 Hz)
//  PW_MIN       1000   minimum pulse width, us
//  PW_MAX       2000   maximum pulse width, us
//  PW_CENTER    1500   home pulse width, us
//  CX           320    screen centre x, pixels
//  CY           240    screen centre y, pixels
//  DEADBAND     8      |error| <= DEADBAND pixels -> no correction on that axis
//  GAIN_SHIFT   3      correction step = |error| >> GAIN_SHIFT, minimum 1 us
// PORTS
//  clk               in   1        system clock
//  reset             in   1        asynchronous, active-high reset
//  v_sync            in   1        camera vsync; its rising edge marks new tracker results
//  aim_x_all         in   16x10    per-region target centre x
//  aim_y_all         in   16x10    per-region target centre y
//  aim_detected_all  in   16       per-region valid flags
//  target_off        in   1        no target for 3 s
//  pan_pwm           out  1        pan servo PWM
//  tilt_pwm          out  1        tilt servo PWM
//  pan_pw            out  11       current pan pulse width, us
//  tilt_pw           out  11       current tilt pulse width, us
//  sel_idx           out  4        region chosen last frame
//  sel_valid         out  1        a region was chosen last frame
//  busy              out  1        high while state != IDLE
// BEHAVIOUR
//  Reset: pan_pw = tilt_pw = PW_CENTER; pwm outputs 0; sel_idx 0; sel_valid 0; FSM in IDLE; tick/us counters 0.
//  v_sync is registered once. frame_start = v_sync & ~v_sync_d.
//  FSM IDLE -> SCAN on frame_start. Tracker outputs are stable from the following cycle on.
//  SCAN: 16 cycles, index 0..15, one region per cycle.
//    - cost = |x-CX| + |y-CY|, 11-bit unsigned.
//    - Only detected regions compete. The lowest cost wins; on a tie the lower index wins.
//  SCAN -> UPDATE after index 15. UPDATE lasts 1 cycle, then -> IDLE. Latency frame_start -> pw update = 18 cycles.
//  UPDATE when a region was chosen: sel_valid=1, sel_idx=winner.
//    - err_x = x - CX and err_y = y - CY, 11-bit signed.
//    - Per axis: if |err| > DEADBAND then step = max(1, |err| >> GAIN_SHIFT).
//    - pan_pw += step when err_x > 0, else -= step.
//    - tilt_pw -= step when err_y > 0 (target below centre), else += step.
//    - Results saturate to [PW_MIN, PW_MAX]; no wrap.
//  UPDATE when no region was chosen: sel_valid=0, sel_idx holds.
//    - target_off=1: home behaviour (see CONFIGURATION).
//    - target_off=0: pan_pw and tilt_pw hold.
//  frame_start during SCAN/UPDATE is ignored; no restart. The frame is lost.
//  PWM:
//    - A prescaler gives a 1 us tick. A us counter runs 0..PERIOD_US-1 and wraps.
//    - Both pw values are shadow-latched at count 0. pwm = (count < shadow). Pulses never glitch mid-period.
//  Reset asserted mid-scan or mid-pulse: immediate return to reset values; PWM low.
// CONFIGURATION
//  TRACK_SWEEP_EN defined: when target_off with no target, pan sweeps to search for a target.
//    - Step is 4 us per frame between PW_MIN and PW_MAX, reversing direction at each limit.
//    - tilt_pw is set to PW_CENTER.
//    - The direction flag resets to +.
//  TRACK_SWEEP_EN undefined: pan_pw = tilt_pw = PW_CENTER in that UPDATE (snap home).
// TESTING
//  Reset, no frames -> pan_pw=tilt_pw=1500; pan_pwm high exactly 1500 us of each 20000 us.
//  Region 5 detected at (400,240), frame_start -> 18 cycles later pan_pw=1510, tilt_pw=1500, sel_idx=5.
//  Regions 2 (330,250) and 9 (325,245) detected -> sel_idx=9; |err| <= 8 on both axes so pw unchanged.
//  Region 0 at (0,0), pan_pw preset 1010 -> pan_pw saturates at 1000; tilt_pw 1500->1530.
//  pw changed mid-period -> current pulse keeps the old width; the next period uses the new one.
//  No detection, target_off=1 -> home (1500/1500) or, with TRACK_SWEEP_EN, pan 1500->1504->1508 per frame.

Source files
------------

// File: rtl/aim_servo_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aim_servo_controller                                          |
// | Purpose  : Once per camera frame, picks the detected region nearest the  |
// |            screen centre. Converts its pixel error into pan/tilt pulse   |
// |            width corrections and drives two hobby-servo PWM outputs.     |
// | Option   : TRACK_SWEEP_EN - with no target and i_target_off set, pan     |
// |            sweeps between PW_MIN and PW_MAX instead of snapping home.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk                 in   1      system clock                           |
// |   reset               in   1      asynchronous active-high reset         |
// |   i_v_sync            in   1      camera vsync, rising edge = new frame  |
// |   i_aim_x_all         in   16x10  per-region target centre x             |
// |   i_aim_y_all         in   16x10  per-region target centre y             |
// |   i_aim_detected_all  in   16     per-region valid flags                 |
// |   i_target_off        in   1      no target seen for a long time         |
// |   o_pan_pwm           out  1      pan servo PWM                          |
// |   o_tilt_pwm          out  1      tilt servo PWM                         |
// |   o_pan_pw            out  11     current pan pulse width, us            |
// |   o_tilt_pw           out  11     current tilt pulse width, us           |
// |   o_sel_idx           out  4      region chosen last frame               |
// |   o_sel_valid         out  1      a region was chosen last frame         |
// |   o_busy              out  1      high while scanning / updating         |
// +--------------------------------------------------------------------------+
module aim_servo_controller #(
  parameter int CLK_PER_US = 25,
  parameter int PERIOD_US  = 20000,
  parameter int PW_MIN     = 1000,
  parameter int PW_MAX     = 2000,
  parameter int PW_CENTER  = 1500,
  parameter int CX         = 320,
  parameter int CY         = 240,
  parameter int DEADBAND   = 8,
  parameter int GAIN_SHIFT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_v_sync,
  input  logic [15:0][9:0] i_aim_x_all,
  input  logic [15:0][9:0] i_aim_y_all,
  input  logic [15:0]      i_aim_detected_all,
  input  logic             i_target_off,
  output logic             o_pan_pwm,
  output logic             o_tilt_pwm,
  output logic [10:0]      o_pan_pw,
  output logic [10:0]      o_tilt_pw,
  output logic [3:0]       o_sel_idx,
  output logic             o_sel_valid,
  output logic             o_busy
);

  localparam int c_PS_W  = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int c_US_W  = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int c_CMP_W = (c_US_W > 11) ? c_US_W : 11;

  localparam logic [10:0] c_CX     = 11'(CX);
  localparam logic [10:0] c_CY     = 11'(CY);
  localparam logic [10:0] c_DB     = 11'(DEADBAND);
  localparam logic [10:0] c_PW_MIN = 11'(PW_MIN);
  localparam logic [10:0] c_PW_MAX = 11'(PW_MAX);
  localparam logic [10:0] c_PW_CTR = 11'(PW_CENTER);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // ---------------------------------------------------------------- helpers
  function automatic logic [10:0] f_absdiff(input logic [10:0] a, input logic [10:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Correction magnitude for one axis; zero inside the deadband, never below 1 outside it.
  function automatic logic [10:0] f_step(input logic [10:0] mag);
    logic [10:0] s;
    s = mag >> GAIN_SHIFT;
    if (mag <= c_DB)      return 11'd0;
    else if (s == 11'd0)  return 11'd1;
    else                  return s;
  endfunction

  function automatic logic [10:0] f_sat(input logic signed [12:0] v);
    if (v < $signed({2'b00, c_PW_MIN}))      return c_PW_MIN;
    else if (v > $signed({2'b00, c_PW_MAX})) return c_PW_MAX;
    else                                     return v[10:0];
  endfunction

  // ------------------------------------------------------------ frame start
  logic r_vs_d;
  logic w_frame_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_vs_d <= 1'b0;
    else       r_vs_d <= i_v_sync;
  end

  assign w_frame_start = i_v_sync & ~r_vs_d;

  // -------------------------------------------------------------------- FSM
  logic [3:0] r_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_frame_start) w_state_nxt = S_SCAN;
      S_SCAN:   if (r_idx == 4'd15) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------- scan
  logic        r_found;
  logic [10:0] r_best_cost;
  logic [3:0]  r_best_idx;
  logic [9:0]  r_best_x;
  logic [9:0]  r_best_y;

  logic [10:0] w_cost;
  logic        w_better;

  assign w_cost = f_absdiff({1'b0, i_aim_x_all[r_idx]}, c_CX)
                + f_absdiff({1'b0, i_aim_y_all[r_idx]}, c_CY);
  // Strict less-than keeps the earlier (lower) index on a tie.
  assign w_better = i_aim_detected_all[r_idx] && (!r_found || (w_cost < r_best_cost));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx       <= 4'd0;
      r_found     <= 1'b0;
      r_best_cost <= 11'd0;
      r_best_idx  <= 4'd0;
      r_best_x    <= 10'd0;
      r_best_y    <= 10'd0;
    end else if (r_state == S_IDLE) begin
      if (w_frame_start) begin
        r_idx   <= 4'd0;
        r_found <= 1'b0;
      end
    end else if (r_state == S_SCAN) begin
      r_idx <= r_idx + 4'd1;
      if (w_better) begin
        r_found     <= 1'b1;
        r_best_cost <= w_cost;
        r_best_idx  <= r_idx;
        r_best_x    <= i_aim_x_all[r_idx];
        r_best_y    <= i_aim_y_all[r_idx];
      end
    end
  end

  // ------------------------------------------------------------ correction
  logic [10:0] r_pan_pw;
  logic [10:0] r_tilt_pw;
  logic [3:0]  r_sel_idx;
  logic        r_sel_valid;

  logic               w_x_pos;
  logic               w_y_pos;
  logic [10:0]        w_step_x;
  logic [10:0]        w_step_y;
  logic signed [12:0] w_pan_wide;
  logic signed [12:0] w_tilt_wide;

  assign w_x_pos  = {1'b0, r_best_x} > c_CX;
  assign w_y_pos  = {1'b0, r_best_y} > c_CY;
  assign w_step_x = f_step(f_absdiff({1'b0, r_best_x}, c_CX));
  assign w_step_y = f_step(f_absdiff({1'b0, r_best_y}, c_CY));

  // Image y grows downward, so a target below centre needs the tilt pulse shortened.
  assign w_pan_wide  = w_x_pos ? ($signed({2'b00, r_pan_pw}) + $signed({2'b00, w_step_x}))
                               : ($signed({2'b00, r_pan_pw}) - $signed({2'b00, w_step_x}));
  assign w_tilt_wide = w_y_pos ? ($signed({2'b00, r_tilt_pw}) - $signed({2'b00, w_step_y}))
                               : ($signed({2'b00, r_tilt_pw}) + $signed({2'b00, w_step_y}));

`ifdef TRACK_SWEEP_EN
  logic               r_sweep_up;
  logic signed [12:0] w_sweep_wide;
  logic [10:0]        w_sweep_pw;
  logic               w_sweep_up_nxt;

  always_comb begin
    w_sweep_wide   = r_sweep_up ? ($signed({2'b00, r_pan_pw}) + 13'sd4)
                                : ($signed({2'b00, r_pan_pw}) - 13'sd4);
    w_sweep_pw     = w_sweep_wide[10:0];
    w_sweep_up_nxt = r_sweep_up;
    if (w_sweep_wide >= $signed({2'b00, c_PW_MAX})) begin
      w_sweep_pw     = c_PW_MAX;
      w_sweep_up_nxt = 1'b0;
    end else if (w_sweep_wide <= $signed({2'b00, c_PW_MIN})) begin
      w_sweep_pw     = c_PW_MIN;
      w_sweep_up_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_sweep_up <= 1'b1;
    else if ((r_state == S_UPDATE) && !r_found && i_target_off)
      r_sweep_up <= w_sweep_up_nxt;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pan_pw    <= c_PW_CTR;
      r_tilt_pw   <= c_PW_CTR;
      r_sel_idx   <= 4'd0;
      r_sel_valid <= 1'b0;
    end else if (r_state == S_UPDATE) begin
      if (r_found) begin
        r_sel_valid <= 1'b1;
        r_sel_idx   <= r_best_idx;
        r_pan_pw    <= f_sat(w_pan_wide);
        r_tilt_pw   <= f_sat(w_tilt_wide);
      end else begin
        r_sel_valid <= 1'b0;
        if (i_target_off) begin
`ifdef TRACK_SWEEP_EN
          r_pan_pw  <= w_sweep_pw;
`else
          r_pan_pw  <= c_PW_CTR;
`endif
          r_tilt_pw <= c_PW_CTR;
        end
      end
    end
  end

  // -------------------------------------------------------------------- PWM
  logic [c_PS_W-1:0] r_ps;
  logic [c_US_W-1:0] r_us;
  logic [10:0]       r_pan_sh;
  logic [10:0]       r_tilt_sh;
  logic              r_pan_pwm;
  logic              r_tilt_pwm;
  logic              w_tick;
  logic              w_wrap;
  logic [c_CMP_W-1:0] w_us_c;

  assign w_tick = (r_ps == c_PS_W'(CLK_PER_US - 1));
  assign w_wrap = (r_us == c_US_W'(PERIOD_US - 1));
  assign w_us_c = c_CMP_W'(r_us);

  // Shadows only reload as the count returns to 0, so a width change never
  // alters a pulse already in progress. Outputs are registered so they sit
  // low while reset is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ps       <= '0;
      r_us       <= '0;
      r_pan_sh   <= c_PW_CTR;
      r_tilt_sh  <= c_PW_CTR;
      r_pan_pwm  <= 1'b0;
      r_tilt_pwm <= 1'b0;
    end else begin
      if (w_tick) begin
        r_ps <= '0;
        if (w_wrap) begin
          r_us      <= '0;
          r_pan_sh  <= r_pan_pw;
          r_tilt_sh <= r_tilt_pw;
        end else begin
          r_us <= r_us + c_US_W'(1);
        end
      end else begin
        r_ps <= r_ps + c_PS_W'(1);
      end
      r_pan_pwm  <= (w_us_c < c_CMP_W'(r_pan_sh));
      r_tilt_pwm <= (w_us_c < c_CMP_W'(r_tilt_sh));
    end
  end

  assign o_pan_pwm   = r_pan_pwm;
  assign o_tilt_pwm  = r_tilt_pwm;
  assign o_pan_pw    = r_pan_pw;
  assign o_tilt_pw   = r_tilt_pw;
  assign o_sel_idx   = r_sel_idx;
  assign o_sel_valid = r_sel_valid;
  assign o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aim_servo_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aim_servo_controller                                       |
// | Purpose  : Directed bench for aim_servo_controller. Frame stimulus pushes |
// |            hand-computed results into a queue; a monitor pops one entry  |
// |            each time the DUT finishes an update (busy falling).          |
// |            PWM runs shortened (2 clk/us, 2100 us period) to keep runtime |
// |            short. Honours TRACK_SWEEP_EN for the no-target cases.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_aim_servo_controller;

  localparam int c_CLK_PER_US = 2;
  localparam int c_PERIOD_US  = 2100;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             v_sync = 1'b0;
  logic [15:0][9:0] ax = '0;
  logic [15:0][9:0] ay = '0;
  logic [15:0]      det = '0;
  logic             toff = 1'b0;
  logic             pan_pwm, tilt_pwm, sel_valid, busy;
  logic [10:0]      pan_pw, tilt_pw;
  logic [3:0]       sel_idx;

  aim_servo_controller #(
    .CLK_PER_US (c_CLK_PER_US),
    .PERIOD_US  (c_PERIOD_US)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_v_sync           (v_sync),
    .i_aim_x_all        (ax),
    .i_aim_y_all        (ay),
    .i_aim_detected_all (det),
    .i_target_off       (toff),
    .o_pan_pwm          (pan_pwm),
    .o_tilt_pwm         (tilt_pwm),
    .o_pan_pw           (pan_pw),
    .o_tilt_pw          (tilt_pw),
    .o_sel_idx          (sel_idx),
    .o_sel_valid        (sel_valid),
    .o_busy             (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] pan;
    logic [10:0] tilt;
    logic [3:0]  idx;
    logic        vld;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] cyc = 0;
  logic        busy_q = 1'b0;
  int          n_upd = 0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // ----------------------------------------------------------------- monitor
  always @(negedge clk) begin
    exp_t e;
    if (busy_q && !busy) begin
      n_upd++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL update%0d: unexpected update pan=%0d tilt=%0d idx=%0d vld=%0d",
                 n_upd, pan_pw, tilt_pw, sel_idx, sel_valid);
      end else begin
        e = exp_q.pop_front();
        if (pan_pw !== e.pan || tilt_pw !== e.tilt || sel_idx !== e.idx ||
            sel_valid !== e.vld || cyc !== e.cyc) begin
          n_bad++;
          $display("FAIL update%0d: got pan=%0d tilt=%0d idx=%0d vld=%0d cyc=%0d, expected pan=%0d tilt=%0d idx=%0d vld=%0d cyc=%0d",
                   n_upd, pan_pw, tilt_pw, sel_idx, sel_valid, cyc,
                   e.pan, e.tilt, e.idx, e.vld, e.cyc);
        end
      end
    end
    busy_q = busy;
  end

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic clr_regions();
    det = '0;
    ax  = '0;
    ay  = '0;
  endtask

  task automatic set_region(input int i, input int x, input int y);
    ax[i]  = 10'(x);
    ay[i]  = 10'(y);
    det[i] = 1'b1;
  endtask

  task automatic push_exp(input int p, input int t, input int i, input bit v);
    exp_t e;
    // v_sync rises at this negedge; update lands 18 posedges later.
    e.pan  = 11'(p);
    e.tilt = 11'(t);
    e.idx  = 4'(i);
    e.vld  = v;
    e.cyc  = cyc + 32'd18;
    exp_q.push_back(e);
  endtask

  // One frame: v_sync pulse, optional second pulse while scanning, then idle.
  task automatic frame(input int p, input int t, input int i, input bit v, input bit retrig);
    @(negedge clk);
    push_exp(p, t, i, v);
    v_sync = 1'b1;
    repeat (3) @(negedge clk);
    v_sync = 1'b0;
    if (retrig) begin
      repeat (3) @(negedge clk);
      v_sync = 1'b1;
      repeat (3) @(negedge clk);
      v_sync = 1'b0;
    end
    repeat (28) @(negedge clk);
  endtask

  // Measure one PWM period starting at a pan rising edge. Optionally launches
  // a frame 100 cycles into the pulse.
  task automatic meas(output int hi_p, output int hi_t, output int lo,
                      input bit inject, input int ip, input int it, input int ii);
    int n;
    hi_p = 0; hi_t = 0; lo = 0; n = 0;
    while (!pan_pwm && n < 10000) begin @(negedge clk); n++; end
    if (n >= 10000) chk("pwm_rise_timeout", 0, 1);
    n = 0;
    while ((pan_pwm || tilt_pwm) && n < 10000) begin
      if (pan_pwm)  hi_p++;
      if (tilt_pwm) hi_t++;
      if (inject && n == 100) begin push_exp(ip, it, ii, 1'b1); v_sync = 1'b1; end
      if (inject && n == 103) v_sync = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 10000) chk("pwm_high_timeout", 0, 1);
    n = 0;
    while (!pan_pwm && n < 10000) begin @(negedge clk); lo++; n++; end
    if (n >= 10000) chk("pwm_low_timeout", 0, 1);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    int hp, ht, lo, p, t;
    repeat (3) @(negedge clk);
    chk("rst_pan_pwm",  int'(pan_pwm), 0);
    chk("rst_tilt_pwm", int'(tilt_pwm), 0);
    reset = 1'b0;
    chk("rst_pan_pw",  int'(pan_pw), 1500);
    chk("rst_tilt_pw", int'(tilt_pw), 1500);
    chk("rst_sel_idx", int'(sel_idx), 0);
    chk("rst_sel_vld", int'(sel_valid), 0);
    chk("rst_busy",    int'(busy), 0);

    // Home pulse width and frame length.
    meas(hp, ht, lo, 1'b0, 0, 0, 0);
    chk("pan_hi_home",  hp, 1500 * c_CLK_PER_US);
    chk("tilt_hi_home", ht, 1500 * c_CLK_PER_US);
    chk("pwm_period",   hp + lo, c_PERIOD_US * c_CLK_PER_US);

    // Region 5 at (400,240): err_x=80 -> step 10. Launched mid-pulse.
    clr_regions();
    set_region(5, 400, 240);
    meas(hp, ht, lo, 1'b1, 1510, 1500, 5);
    chk("pan_hi_old_width", hp, 1500 * c_CLK_PER_US);
    meas(hp, ht, lo, 1'b0, 0, 0, 0);
    chk("pan_hi_new_width", hp, 1510 * c_CLK_PER_US);
    chk("tilt_hi_same",     ht, 1500 * c_CLK_PER_US);

    // Regions 2 (cost 20) and 9 (cost 10): 9 wins, both errors inside deadband.
    clr_regions();
    set_region(2, 330, 250);
    set_region(9, 325, 245);
    frame(1510, 1500, 9, 1'b1, 1'b0);

    // Tie at cost 20 between 3 and 12: lower index. Undetected region 1 at centre ignored.
    clr_regions();
    set_region(3, 340, 240);
    set_region(12, 300, 240);
    ax[1] = 10'd320; ay[1] = 10'd240;
    frame(1512, 1500, 3, 1'b1, 1'b0);

    // Region 0 at (0,0): pan -40, tilt +30 per frame until saturation.
    clr_regions();
    set_region(0, 0, 0);
    ax[1] = 10'd320; ay[1] = 10'd240;
    frame(1472, 1530, 0, 1'b1, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      p = 1472 - 40 * i; if (p < 1000) p = 1000;
      t = 1530 + 30 * i; if (t > 2000) t = 2000;
      frame(p, t, 0, 1'b1, 1'b0);
    end

    // Target below centre lowers tilt; pan err 0.
    clr_regions();
    set_region(7, 320, 400);
    frame(1000, 1980, 7, 1'b1, 1'b0);

    // Extreme corner: steps 87 / 97.
    clr_regions();
    set_region(15, 1023, 1023);
    frame(1087, 1883, 15, 1'b1, 1'b0);

    // Deadband edge: |err|=9 moves by 1, |err|=8 holds.
    clr_regions();
    set_region(4, 329, 231);
    frame(1088, 1884, 4, 1'b1, 1'b0);
    clr_regions();
    set_region(4, 328, 232);
    frame(1088, 1884, 4, 1'b1, 1'b0);

    // No target, target_off low: hold, sel_idx holds.
    clr_regions();
    toff = 1'b0;
    frame(1088, 1884, 4, 1'b0, 1'b0);

    // No target, target_off high: home or sweep.
    toff = 1'b1;
`ifdef TRACK_SWEEP_EN
    frame(1092, 1500, 4, 1'b0, 1'b0);
    frame(1096, 1500, 4, 1'b0, 1'b0);
    p = 1096 + 10;
`else
    frame(1500, 1500, 4, 1'b0, 1'b0);
    frame(1500, 1500, 4, 1'b0, 1'b0);
    p = 1500 + 10;
`endif
    toff = 1'b0;

    // Second v_sync edge during scan is ignored: one update, normal latency.
    set_region(5, 400, 240);
    frame(p, 1500, 5, 1'b1, 1'b1);

    begin
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      chk("pending_updates", exp_q.size(), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
